uart_rx_capture: RTL and testbench
==================================

// Module: uart_rx_capture
// PURPOSE
//  Serial receive stage for the user project. Consumes the UART RX pad stream (io_in[5]) that the
//  wrapper already loops back to io_out[6]. Deframes 8N1 bytes into a small FIFO that the management
//  SoC reads over the Wishbone slave port, and raises user_irq[0] while data is pending.
// PARAMETERS
//  FIFO_DEPTH   8           entries; power of two, 2..16
//  DEFAULT_DIV  16'd868     reset value of DIVISOR (wb_clk_i cycles per bit; 100 MHz / 115200)
//  BASE_ADR     32'h3000_0000  Wishbone base; decodes adr[31:4] == BASE_ADR[31:4]
// PORTS
//  wb_clk_i     in   1   single clock domain
//  wb_rst_ni    in   1   asynchronous, active-low reset
//  rx_i         in   1   raw serial input (io_in[5]); asynchronous to wb_clk_i
//  wbs_cyc_i    in   1   Wishbone cycle
//  wbs_stb_i    in   1   Wishbone strobe
//  wbs_we_i     in   1   write enable
//  wbs_sel_i    in   4   byte selects; only sel[0] is honoured, for writes
//  wbs_adr_i    in   32  byte address; reg = adr[3:2]
//  wbs_dat_i    in   32  write data
//  wbs_ack_o    out  1   single-cycle acknowledge
//  wbs_dat_o    out  32  read data; valid only with ack, 0 otherwise
//  irq_o        out  1   level: IRQ_EN & (fifo not empty | overrun | frame_err)
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, errors clear, DIVISOR = DEFAULT_DIV, IRQ_EN = 0, FSM in IDLE.
//  rx_i: 2-FF synchroniser; the FF reset value is 1 (line idle).
//  Register map (word offsets):
//   0x0 DATA    R: {24'b0, head byte}; pops 1 entry. Empty -> returns 0, no pop. W: ignored.
//   0x4 STATUS  R: {22'b0, count[4:0], overrun, frame_err, full, empty, busy}, where busy = FSM != IDLE.
//               W: a 1 in bit[2]/bit[3] clears frame_err/overrun (W1C).
//   0x8 DIVISOR R/W [15:0]. Writes < 4 store 4. The new value is applied to the bit timer at the next IDLE.
//   0xC CTRL    R/W bit[0] IRQ_EN.
//  Wishbone: on cyc&stb&!ack, ack is asserted the next cycle for exactly 1 cycle (never back-to-back).
//   Reads and writes complete with that ack. Side effects (pop, W1C) happen in the ack cycle, once per access.
//   Addresses outside the decode window are never acked.
//  Receive FSM (bit timer counts DIVISOR-1 down to 0):
//   IDLE  -> START on a synchronised 1->0 edge; timer loaded with DIVISOR/2.
//   START -> at timer 0: if rx==0, go to DATA (bit idx 0) with timer = DIVISOR;
//            else back to IDLE (glitch; no error flag).
//   DATA  -> sample rx at each timer expiry, LSB first. After bit 7, go to STOP.
//   STOP  -> sample at expiry. rx==1: push the byte. rx==0: set frame_err, discard the byte.
//            Either way -> IDLE.
//   Divisor change mid-frame has no effect until IDLE.
//  FIFO: push when full -> byte dropped, overrun set. If a pop is in the same cycle, both occur;
//   count is unchanged and no overrun.
//   Count wraps never; pointers wrap modulo FIFO_DEPTH.
//  Latency: byte visible in DATA/STATUS 1 cycle after the stop-bit sample.
//  Reset mid-frame: FSM aborts to IDLE and the partial byte is lost.
// STRUCTURE
//  Package uart_rx_pkg: FSM state enum (IDLE, START, DATA, STOP), register offset localparams,
//   STATUS bit indices, MIN_DIV = 4.
//  One sub-module, sync_fifo (parameterised width 8 / depth FIFO_DEPTH, with count/full/empty).
//   The deframer and Wishbone regs stay in this module.
// TESTING (DIVISOR = 8 unless noted)
//  1 Send 0xA5, then read STATUS -> empty=0, count=1; read DATA -> 0xA5.
//    Second read of DATA -> 0, and STATUS.empty = 1.
//  2 Apply a 3-cycle low glitch on rx -> FSM returns to IDLE, no push, frame_err=0.
//  3 Send 0x3C with the stop bit held low -> frame_err=1, count=0.
//    Write STATUS 0x4 -> frame_err=0.
//  4 Send 9 bytes 0x01..0x09 without reading -> count=8, full=1, overrun=1.
//    Drain yields 0x01..0x08.
//  5 Pop in the same cycle as a push while full -> count stays 8, overrun unchanged.
//  6 Write DIVISOR=2 -> reads back 4. Write 16 mid-frame -> current byte is still correct at 8,
//    and the next byte is received correctly at 16.
//    Assert wb_rst_ni mid-frame -> all outputs 0, no stray byte.

Source files
------------

// File: rtl/uart_rx_capture_pkg.sv
// Shared types and constants for the UART receive capture block.
package uart_rx_pkg;

    // Receive deframer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Register word offsets (adr[3:2])
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS read-back bit positions
    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_OVERRUN   = 4;
    localparam int STAT_COUNT_LSB = 5;

    // STATUS write-one-to-clear bit positions
    localparam int W1C_FRAME_ERR  = 2;
    localparam int W1C_OVERRUN    = 3;

    // Smallest divisor the bit timer can work with
    localparam logic [15:0] MIN_DIV = 16'd4;

    // Clamp a requested divisor to the supported minimum
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

endpackage

// File: rtl/uart_rx_capture_fifo.sv
// Small synchronous FIFO with occupancy count; a push while full is dropped
// unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr];
    assign count = count_q;

    // Storage array, written at the tail pointer
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_capture.sv
// UART 8N1 receiver with a byte FIFO and a Wishbone register slave.
module uart_rx_capture
    import uart_rx_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        rx_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        irq_o
);

    localparam int CW = 5;

    logic        rx_meta, rx_sync, rx_prev, rx_fall;
    rx_state_t   state, next_state;
    logic [15:0] timer, timer_load_val, divisor, active_div;
    logic        timer_load, sample_bit, clear_bits, push, set_frame_err;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        frame_err, overrun, irq_en;

    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_pop;

    logic        hit, req_we, req_sel0;
    logic [1:0]  req_reg;
    logic [15:0] req_dat;
    logic        rd_access, wr_access, status_w1c;
    logic [31:0] read_data;
    logic        unused_bits;

    assign unused_bits = ^{wbs_sel_i[3:1], wbs_adr_i[1:0], wbs_dat_i[31:16]};
    assign rx_fall     = rx_prev & ~rx_sync;

    // Two-flop synchroniser plus edge history; idle line is high
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Deframer state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Deframer next-state and datapath controls
    always_comb begin
        next_state     = state;
        timer_load     = 1'b0;
        timer_load_val = '0;
        sample_bit     = 1'b0;
        clear_bits     = 1'b0;
        push           = 1'b0;
        set_frame_err  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    next_state     = START;
                    timer_load     = 1'b1;
                    timer_load_val = divisor >> 1;
                end
            end
            START: begin
                if (timer == '0) begin
                    if (!rx_sync) begin
                        next_state     = DATA;
                        timer_load     = 1'b1;
                        timer_load_val = active_div - 16'd1;
                        clear_bits     = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer == '0) begin
                    sample_bit     = 1'b1;
                    timer_load     = 1'b1;
                    timer_load_val = active_div - 16'd1;
                    if (bit_idx == 3'd7) begin
                        next_state = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == '0) begin
                    push          = rx_sync;
                    set_frame_err = ~rx_sync;
                    next_state    = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Bit timer, bit index and shift register; divisor is only picked up while idle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            timer      <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            active_div <= DEFAULT_DIV;
        end else begin
            if (state == IDLE) begin
                active_div <= divisor;
            end
            if (timer_load) begin
                timer <= timer_load_val;
            end else if (timer != '0) begin
                timer <= timer - 16'd1;
            end
            if (clear_bits) begin
                bit_idx <= '0;
            end
            if (sample_bit) begin
                shift_reg <= {rx_sync, shift_reg[7:1]};
                bit_idx   <= bit_idx + 3'd1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .push  (push),
        .pop   (fifo_pop),
        .wdata (shift_reg),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign rd_access  = wbs_ack_o & ~req_we;
    assign wr_access  = wbs_ack_o & req_we & req_sel0;
    assign fifo_pop   = rd_access & (req_reg == REG_DATA) & ~fifo_empty;
    assign status_w1c = wr_access & (req_reg == REG_STATUS);

    // Single-cycle ack one clock after the request; request fields captured for the ack cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o <= 1'b0;
            req_we    <= 1'b0;
            req_sel0  <= 1'b0;
            req_reg   <= '0;
            req_dat   <= '0;
        end else begin
            wbs_ack_o <= hit & ~wbs_ack_o;
            if (hit && !wbs_ack_o) begin
                req_we   <= wbs_we_i;
                req_sel0 <= wbs_sel_i[0];
                req_reg  <= wbs_adr_i[3:2];
                req_dat  <= wbs_dat_i[15:0];
            end
        end
    end

    // Writable configuration registers
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            divisor <= DEFAULT_DIV;
            irq_en  <= 1'b0;
        end else if (wr_access) begin
            if (req_reg == REG_DIVISOR) begin
                divisor <= clamp_div(req_dat);
            end
            if (req_reg == REG_CTRL) begin
                irq_en <= req_dat[0];
            end
        end
    end

    // Sticky error flags; a new error in the same cycle wins over a clear
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (status_w1c && req_dat[W1C_FRAME_ERR]) begin
                frame_err <= 1'b0;
            end
            if (status_w1c && req_dat[W1C_OVERRUN]) begin
                overrun <= 1'b0;
            end
            if (set_frame_err) begin
                frame_err <= 1'b1;
            end
            if (push && fifo_full && !fifo_pop) begin
                overrun <= 1'b1;
            end
        end
    end

    // Read data mux; bus is zero outside a read ack
    always_comb begin
        read_data = '0;
        if (rd_access) begin
            case (req_reg)
                REG_DATA:    read_data = fifo_empty ? 32'd0 : {24'd0, fifo_rdata};
                REG_STATUS:  read_data = {22'd0, fifo_count, overrun, frame_err,
                                          fifo_full, fifo_empty, (state != IDLE)};
                REG_DIVISOR: read_data = {16'd0, divisor};
                REG_CTRL:    read_data = {31'd0, irq_en};
                default:     read_data = '0;
            endcase
        end
    end

    assign wbs_dat_o = read_data;
    assign irq_o     = irq_en & (~fifo_empty | overrun | frame_err);

endmodule

// File: tb/tb_uart_rx_capture.sv
// Scoreboard bench for uart_rx_capture: reads queue their expected data,
// a monitor compares whenever a read is acknowledged.
`timescale 1ns/1ps
module tb_uart_rx_capture;

    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_DATA   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_DIV    = BASE + 32'h8;
    localparam logic [31:0] A_CTRL   = BASE + 32'hC;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx    = 1'b1;
    logic        cyc   = 1'b0;
    logic        stb   = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  sel   = 4'h0;
    logic [31:0] adr   = '0;
    logic [31:0] wdat  = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   seen_ack;

    always #5 clk = ~clk;

    uart_rx_capture dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .rx_i      (rx),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .irq_o     (irq)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected STATUS word for an idle receiver with an 8-deep FIFO
    function automatic logic [31:0] stat(input int cnt, input bit ovr, input bit fe);
        logic [31:0] s;
        s       = '0;
        s[9:5]  = cnt[4:0];
        s[4]    = ovr;
        s[3]    = fe;
        s[2]    = (cnt == 8);
        s[1]    = (cnt == 0);
        return s;
    endfunction

    // One Wishbone access; reads queue their expectation for the monitor
    task automatic applyStimulus(input bit is_write, input logic [31:0] a, input logic [31:0] d,
                                 input string name, input logic [31:0] exp);
        int n;
        if (!is_write) sb_q.push_back('{name, exp});
        @(negedge clk);
        cyc  = 1'b1;
        stb  = 1'b1;
        we   = is_write;
        adr  = a;
        wdat = d;
        sel  = 4'hF;
        n    = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack && n < 8);
        if (!ack) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack_timeout %s: got no ack, expected ack within 8 cycles", name);
            if (!is_write && sb_q.size() > 0) void'(sb_q.pop_back());
        end
        @(negedge clk);
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b1, a, d, "write", 32'd0);
    endtask

    task automatic wb_read(input logic [31:0] a, input string name, input logic [31:0] exp);
        applyStimulus(1'b0, a, 32'd0, name, exp);
    endtask

    // Drive one 8N1 frame, LSB first, div clocks per bit
    task automatic send_frame(input logic [7:0] b, input bit stop, input int div);
        @(negedge clk);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div) @(negedge clk);
        end
        rx = stop;
        repeat (div) @(negedge clk);
        rx = 1'b1;
    endtask

    // Monitor: every acknowledged read is matched against the scoreboard head
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack && !we) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_read: got 0x%08h, expected no read", rdat);
                end else begin
                    mon_e = sb_q.pop_front();
                    checkOutput(mon_e.name, rdat, mon_e.exp);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion within 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_ack", {31'd0, ack}, 32'd0);
        checkOutput("reset_dat", rdat, 32'd0);
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        wb_read(A_STATUS, "reset_status", stat(0, 0, 0));
        wb_read(A_DIV, "reset_divisor", 32'd868);
        wb_read(A_CTRL, "reset_ctrl", 32'd0);

        // Outside the decode window nothing acks
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
        seen_ack = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (ack) seen_ack++;
        end
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        checkOutput("no_ack_outside", 32'(seen_ack), 32'd0);

        wb_write(A_DIV, 32'd8);
        wb_write(A_CTRL, 32'd1);

        // 1: single byte, read back, then empty
        send_frame(8'hA5, 1'b1, 8);
        checkOutput("t1_irq_pending", {31'd0, irq}, 32'd1);
        wb_read(A_STATUS, "t1_status", stat(1, 0, 0));
        wb_read(A_DATA, "t1_data", 32'hA5);
        wb_read(A_DATA, "t1_data_empty", 32'd0);
        wb_read(A_STATUS, "t1_status_empty", stat(0, 0, 0));
        checkOutput("t1_irq_clear", {31'd0, irq}, 32'd0);

        // 2: short low glitch is rejected
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        wb_read(A_STATUS, "t2_glitch_status", stat(0, 0, 0));

        // 3: bad stop bit, then W1C
        send_frame(8'h3C, 1'b0, 8);
        wb_read(A_STATUS, "t3_frame_err", stat(0, 0, 1));
        checkOutput("t3_irq_frame_err", {31'd0, irq}, 32'd1);
        wb_write(A_STATUS, 32'h4);
        wb_read(A_STATUS, "t3_cleared", stat(0, 0, 0));

        // 4: overflow by one byte
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 8);
        wb_read(A_STATUS, "t4_full_overrun", stat(8, 1, 0));
        for (int i = 1; i <= 8; i++) wb_read(A_DATA, "t4_drain", 32'(i));
        wb_read(A_STATUS, "t4_drained", stat(0, 1, 0));
        wb_write(A_STATUS, 32'h8);
        wb_read(A_STATUS, "t4_overrun_cleared", stat(0, 0, 0));

        // 5: pop in the same cycle as a push while full
        for (int i = 0; i < 8; i++) send_frame(8'h11 + 8'(i), 1'b1, 8);
        wb_read(A_STATUS, "t5_full", stat(8, 0, 0));
        fork
            send_frame(8'h19, 1'b1, 8);
            begin
                @(negedge clk);
                repeat (78) @(posedge clk);
                wb_read(A_DATA, "t5_pop_with_push", 32'h11);
            end
        join
        wb_read(A_STATUS, "t5_still_full", stat(8, 0, 0));
        for (int i = 0; i < 8; i++) wb_read(A_DATA, "t5_drain", 32'h12 + 32'(i));
        wb_read(A_STATUS, "t5_drained", stat(0, 0, 0));

        // 6: divisor clamp, mid-frame change, reset mid-frame
        wb_write(A_DIV, 32'd2);
        wb_read(A_DIV, "t6_div_clamp", 32'd4);
        wb_write(A_DIV, 32'd8);
        fork
            send_frame(8'h5A, 1'b1, 8);
            begin
                repeat (30) @(posedge clk);
                wb_write(A_DIV, 32'd16);
                wb_read(A_STATUS, "t6_busy", stat(0, 0, 0) | 32'h1);
            end
        join
        send_frame(8'hC3, 1'b1, 16);
        wb_read(A_DATA, "t6_old_div_byte", 32'h5A);
        wb_read(A_DIV, "t6_div_16", 32'd16);
        checkOutput("t6_irq_before_reset", {31'd0, irq}, 32'd1);
        fork
            send_frame(8'h77, 1'b1, 16);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                checkOutput("t6_reset_ack", {31'd0, ack}, 32'd0);
                checkOutput("t6_reset_dat", rdat, 32'd0);
                checkOutput("t6_reset_irq", {31'd0, irq}, 32'd0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wb_read(A_STATUS, "t6_after_reset_status", stat(0, 0, 0));
        wb_read(A_DATA, "t6_no_stray_byte", 32'd0);
        wb_read(A_DIV, "t6_after_reset_div", 32'd868);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
